// File: rtl/mem_access_unit.sv
// Load/store access unit: issues one aligned bus request per memory op, waits for the
// ack (bounded by a timeout), and drives writeback for loads and non-memory passthrough.
module mem_access_unit #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned RADDR_W     = 5,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Valid_i,
   input  logic [3:0]            MemOp_i,
   input  logic [ADDR_W-1:0]     Addr_i,
   input  logic [DATA_W-1:0]     StoreData_i,
   input  logic [DATA_W-1:0]     WriteData_i,
   input  logic                  WriteReg_i,
   input  logic [RADDR_W-1:0]    WriteDataAddr_i,
   output logic                  MemReq_o,
   output logic                  MemWE_o,
   output logic [DATA_W/8-1:0]   MemBE_o,
   output logic [ADDR_W-1:0]     MemAddr_o,
   output logic [DATA_W-1:0]     MemWData_o,
   input  logic                  MemAck_i,
   input  logic [DATA_W-1:0]     MemRData_i,
   output logic                  Stall_o,
   output logic                  WriteReg_o,
   output logic [RADDR_W-1:0]    WriteDataAddr_o,
   output logic [DATA_W-1:0]     WriteData_o,
   output logic                  Misalign_o,
   output logic                  Timeout_o
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned LSB_W = $clog2(BE_W);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         funct3_q;
   logic               store_q;
   logic [LSB_W-1:0]   off_q;
   logic [RADDR_W-1:0] rd_q;

   logic               is_mem, is_half, is_word, misalign, issue, timeout;
   logic [3:0]         be_base;
   logic [BE_W-1:0]    be_new;
   logic [DATA_W-1:0]  wdat_new, lane, load_ext;

   logic               req_d, we_d, wreg_d, mis_d, to_d;
   logic [BE_W-1:0]    be_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  wdat_d, wbd_d;
   logic [RADDR_W-1:0] wrd_d;

   // Decode the incoming op: size, alignment, lane enables and replicated store data.
   always_comb begin
      is_mem   = (MemOp_i != 4'b1111);
      is_half  = (MemOp_i[1:0] == 2'b01);
      is_word  = MemOp_i[1];
      misalign = (is_half && Addr_i[0]) || (is_word && (Addr_i[1:0] != 2'b00));
      issue    = (state_q == StIdle) && Valid_i && is_mem && !misalign;
      timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      be_base  = is_word ? 4'hF : (is_half ? 4'h3 : 4'h1);
      be_new   = BE_W'(be_base) << Addr_i[LSB_W-1:0];
      if (is_word)      wdat_new = {(DATA_W/32){StoreData_i[31:0]}};
      else if (is_half) wdat_new = {(DATA_W/16){StoreData_i[15:0]}};
      else              wdat_new = {(DATA_W/8){StoreData_i[7:0]}};
   end

   // Shift the addressed lane down and extend it according to the latched funct3.
   always_comb begin
      lane = MemRData_i >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_ext = DATA_W'($signed(lane[7:0]));
         3'b001:  load_ext = DATA_W'($signed(lane[15:0]));
         3'b100:  load_ext = DATA_W'(lane[7:0]);
         3'b101:  load_ext = DATA_W'(lane[15:0]);
         default: load_ext = DATA_W'($signed(lane[31:0]));
      endcase
   end

   // Upstream hold; forced low while reset is asserted.
   assign Stall_o = rst && (issue || (state_q == StBusy));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // Next-state logic; ack wins over a timeout landing in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (issue) state_d = StBusy;
         StBusy: begin
            if (MemAck_i)     state_d = StDone;
            else if (timeout) state_d = StIdle;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs; bus fields hold unless a new op issues.
   always_comb begin
      req_d  = 1'b0;
      we_d   = MemWE_o;
      be_d   = MemBE_o;
      addr_d = MemAddr_o;
      wdat_d = MemWData_o;
      wreg_d = 1'b0;
      wrd_d  = WriteDataAddr_o;
      wbd_d  = WriteData_o;
      mis_d  = 1'b0;
      to_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Valid_i) begin
               if (!is_mem) begin
                  wreg_d = WriteReg_i;
                  wrd_d  = WriteDataAddr_i;
                  wbd_d  = WriteData_i;
               end else if (misalign) begin
                  mis_d = 1'b1;
               end else begin
                  req_d  = 1'b1;
                  we_d   = MemOp_i[3];
                  be_d   = be_new;
                  addr_d = {Addr_i[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                  wdat_d = wdat_new;
               end
            end
         end
         StBusy: begin
            if (MemAck_i) begin
               if (!store_q) begin
                  wreg_d = 1'b1;
                  wrd_d  = rd_q;
                  wbd_d  = load_ext;
               end
            end else if (timeout) begin
               to_d = 1'b1;
            end else begin
               req_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         MemReq_o        <= 1'b0;
         MemWE_o         <= 1'b0;
         MemBE_o         <= '0;
         MemAddr_o       <= '0;
         MemWData_o      <= '0;
         WriteReg_o      <= 1'b0;
         WriteDataAddr_o <= '0;
         WriteData_o     <= '0;
         Misalign_o      <= 1'b0;
         Timeout_o       <= 1'b0;
      end else begin
         MemReq_o        <= req_d;
         MemWE_o         <= we_d;
         MemBE_o         <= be_d;
         MemAddr_o       <= addr_d;
         MemWData_o      <= wdat_d;
         WriteReg_o      <= wreg_d;
         WriteDataAddr_o <= wrd_d;
         WriteData_o     <= wbd_d;
         Misalign_o      <= mis_d;
         Timeout_o       <= to_d;
      end
   end

   // Wait counter and the op fields needed to finish the transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         funct3_q <= '0;
         store_q  <= 1'b0;
         off_q    <= '0;
         rd_q     <= '0;
      end else begin
         cnt_q <= (state_q == StBusy) ? cnt_q + CNT_W'(1) : '0;
         if (issue) begin
            funct3_q <= MemOp_i[2:0];
            store_q  <= MemOp_i[3];
            off_q    <= Addr_i[LSB_W-1:0];
            rd_q     <= WriteDataAddr_i;
         end
      end
   end

endmodule
